// File: rtl/cnn_pkg.sv
// cnn_pkg - shared types and helpers for the CNN datapath blocks.
//   DATA_W        default signed activation width
//   pool_state_t  row phase of the 2x2 pooling stage
//   smax()        signed maximum of two activations, result stays DATA_W wide
package cnn_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, ROW_SKIP} pool_state_t;

   function automatic logic signed [DATA_W-1:0] smax(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_rowbuf.sv
// pool_rowbuf - line buffer holding one horizontally pooled vector per output
// column, written while the even row streams in and read back on the odd row.
// Contents are not reset; every entry is written before it is read in a frame.
//   clk    clock
//   we     write enable
//   waddr  write column (output-column index)
//   wdata  CH x DATA_W vector to store
//   raddr  read column, combinational read
//   rdata  CH x DATA_W vector at raddr
module pool_rowbuf #(
   parameter  int CH     = 16,
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 14,
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic signed [DATA_W-1:0] wdata [0:CH-1],
   input  logic [AW-1:0]            raddr,
   output logic signed [DATA_W-1:0] rdata [0:CH-1]
);

   logic signed [DATA_W-1:0] mem [0:DEPTH-1][0:CH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_vec.sv
// maxpool2x2_vec - 2x2 stride-2 max pooling over a raster stream of CH-wide
// signed activation vectors. Valid-only, no backpressure, one vector per cycle.
// Optional build macro MAXPOOL_RELU_EN clamps each pooled channel at zero.
//   clk         clock
//   rst         asynchronous active-high reset
//   in_vector   CH x DATA_W input activation vector
//   in_valid    qualifies in_vector
//   out_vector  CH x DATA_W pooled vector, held between out_valid pulses
//   out_valid   one-cycle pulse per pooled vector
//   out_x/out_y output column/row of the current pooled vector
//   frame_done  pulses with the last out_valid of a frame
module maxpool2x2_vec #(
   parameter  int CH     = 16,
   parameter  int IN_H   = 28,
   parameter  int IN_W   = 28,
   parameter  int DATA_W = cnn_pkg::DATA_W,
   localparam int OUT_H  = IN_H / 2,
   localparam int OUT_W  = IN_W / 2,
   localparam int XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1,
   localparam int YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] in_vector [0:CH-1],
   input  logic                     in_valid,
   output logic signed [DATA_W-1:0] out_vector [0:CH-1],
   output logic                     out_valid,
   output logic [XW-1:0]            out_x,
   output logic [YW-1:0]            out_y,
   output logic                     frame_done
);

   import cnn_pkg::*;

   localparam int CXW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int CYW = (IN_H > 1) ? $clog2(IN_H) : 1;

   localparam logic [CXW-1:0] X_LAST = CXW'(IN_W - 1);
   localparam logic [CYW-1:0] Y_LAST = CYW'(IN_H - 1);
   localparam logic [CYW-1:0] Y_PEN  = CYW'(IN_H - 2);
   localparam logic [CXW-1:0] X_FD   = CXW'(2 * OUT_W - 1);
   localparam logic [CYW-1:0] Y_FD   = CYW'(2 * OUT_H - 1);
   localparam bit             W_ODD  = (IN_W % 2) == 1;
   localparam bit             H_ODD  = (IN_H % 2) == 1;

   function automatic logic signed [DATA_W-1:0] relu_clamp(
      input logic signed [DATA_W-1:0] v
   );
`ifdef MAXPOOL_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   pool_state_t              state, state_nxt;
   logic [CXW-1:0]           x;
   logic [CYW-1:0]           y;
   logic                     x_last, x_pool;

   logic signed [DATA_W-1:0] hold_p0    [0:CH-1];
   logic signed [DATA_W-1:0] pair_max   [0:CH-1];
   logic signed [DATA_W-1:0] col_max    [0:CH-1];
   logic signed [DATA_W-1:0] rd_vec     [0:CH-1];
   logic                     rb_we;

   logic signed [DATA_W-1:0] out_vec_p1 [0:CH-1];
   logic                     vld_p1;
   logic [XW-1:0]            ox_p1;
   logic [YW-1:0]            oy_p1;
   logic                     fd_p1;

   assign x_last = (x == X_LAST);
   // The trailing column of an odd-width map never joins a 2x2 block.
   assign x_pool = !(W_ODD && x_last);

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         pair_max[c] = smax(hold_p0[c], in_vector[c]);
         col_max[c]  = smax(rd_vec[c], in_vector[c]);
      end
   end

   assign rb_we = in_valid && (state == ROW_EVEN) && x[0];

   pool_rowbuf #(
      .CH     (CH),
      .DATA_W (DATA_W),
      .DEPTH  (OUT_W)
   ) u_rowbuf (
      .clk   (clk),
      .we    (rb_we),
      .waddr (XW'(x >> 1)),
      .wdata (pair_max),
      .raddr (XW'(x >> 1)),
      .rdata (rd_vec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ROW_EVEN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (in_valid && x_last) begin
         case (state)
            ROW_EVEN: state_nxt = ROW_ODD;
            ROW_ODD:  state_nxt = (H_ODD && (y == Y_PEN)) ? ROW_SKIP : ROW_EVEN;
            default:  state_nxt = ROW_EVEN;
         endcase
      end
   end

   // ---- stage p0: raster counters and horizontal/vertical hold register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
         for (int c = 0; c < CH; c++) hold_p0[c] <= '0;
      end else if (in_valid) begin
         if (x_last) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
         if (!x[0] && x_pool) begin
            if (state == ROW_EVEN)
               hold_p0 <= in_vector;
            else if (state == ROW_ODD)
               hold_p0 <= col_max;
         end
      end
   end

   // ---- stage p1: pooled output register (with optional ReLU) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) out_vec_p1[c] <= '0;
         vld_p1 <= 1'b0;
         ox_p1  <= '0;
         oy_p1  <= '0;
         fd_p1  <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         fd_p1  <= 1'b0;
         if (in_valid && (state == ROW_ODD) && x[0]) begin
            for (int c = 0; c < CH; c++) out_vec_p1[c] <= relu_clamp(pair_max[c]);
            vld_p1 <= 1'b1;
            ox_p1  <= XW'(x >> 1);
            oy_p1  <= YW'(y >> 1);
            fd_p1  <= (x == X_FD) && (y == Y_FD);
         end
      end
   end

   assign out_vector = out_vec_p1;
   assign out_valid  = vld_p1;
   assign out_x      = ox_p1;
   assign out_y      = oy_p1;
   assign frame_done = fd_p1;

endmodule

// File: tb/tb_maxpool2x2_vec.sv
// Self-checking bench for maxpool2x2_vec: three instances (4x4, 5x5, 28x28,
// two channels each) driven from one initial block, checked against a
// block-maximum model computed from a stored frame.
module tb_maxpool2x2_vec;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic signed [7:0] iv4 [0:1], iv5 [0:1], iv28 [0:1];
   logic signed [7:0] ov4 [0:1], ov5 [0:1], ov28 [0:1];
   logic val4 = 1'b0, val5 = 1'b0, val28 = 1'b0;
   logic ovld4, ovld5, ovld28, fd4, fd5, fd28;
   logic [0:0] ox4, oy4, ox5, oy5;
   logic [3:0] ox28, oy28;

   maxpool2x2_vec #(.CH(2), .IN_H(4), .IN_W(4), .DATA_W(8)) u_dut4 (
      .clk(clk), .rst(rst), .in_vector(iv4), .in_valid(val4), .out_vector(ov4),
      .out_valid(ovld4), .out_x(ox4), .out_y(oy4), .frame_done(fd4));
   maxpool2x2_vec #(.CH(2), .IN_H(5), .IN_W(5), .DATA_W(8)) u_dut5 (
      .clk(clk), .rst(rst), .in_vector(iv5), .in_valid(val5), .out_vector(ov5),
      .out_valid(ovld5), .out_x(ox5), .out_y(oy5), .frame_done(fd5));
   maxpool2x2_vec #(.CH(2), .IN_H(28), .IN_W(28), .DATA_W(8)) u_dut28 (
      .clk(clk), .rst(rst), .in_vector(iv28), .in_valid(val28), .out_vector(ov28),
      .out_valid(ovld28), .out_x(ox28), .out_y(oy28), .frame_done(fd28));

   int n_chk = 0;
   int n_fail = 0;
   int sel = 0;
   int pix [28][28][2];
   int cap0 [$];
   int cap1 [$];

   logic m_vld, m_fd;
   int   m_v0, m_v1, m_x, m_y;

   always_comb begin
      m_vld = 1'b0; m_fd = 1'b0; m_v0 = 0; m_v1 = 0; m_x = 0; m_y = 0;
      case (sel)
         0: begin m_vld = ovld4;  m_fd = fd4;  m_v0 = int'(ov4[0]);  m_v1 = int'(ov4[1]);
                  m_x = int'(ox4);  m_y = int'(oy4);  end
         1: begin m_vld = ovld5;  m_fd = fd5;  m_v0 = int'(ov5[0]);  m_v1 = int'(ov5[1]);
                  m_x = int'(ox5);  m_y = int'(oy5);  end
         default: begin m_vld = ovld28; m_fd = fd28; m_v0 = int'(ov28[0]); m_v1 = int'(ov28[1]);
                  m_x = int'(ox28); m_y = int'(oy28); end
      endcase
   end

   task automatic drive(input int s, input logic v, input int d0, input int d1);
      case (s)
         0: begin val4 = v;  iv4[0] = 8'(d0);  iv4[1] = 8'(d1);  end
         1: begin val5 = v;  iv5[0] = 8'(d0);  iv5[1] = 8'(d1);  end
         default: begin val28 = v; iv28[0] = 8'(d0); iv28[1] = 8'(d1); end
      endcase
   endtask

   // Reference: maximum over the 2x2 block, then optional clamp at zero.
   function automatic int exp_pool(input int oy, input int ox, input int c);
      int m;
      m = pix[2*oy][2*ox][c];
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++)
            if (pix[2*oy+dy][2*ox+dx][c] > m) m = pix[2*oy+dy][2*ox+dx][c];
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = 0;
`endif
      return m;
   endfunction

   function automatic int relu_ref(input int v);
`ifdef MAXPOOL_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic fill_ramp(input int h, input int w);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            pix[y][x][0] = y * w + x;
            pix[y][x][1] = -(y * w + x);
         end
   endtask

   task automatic fill_random(input int h, input int w);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            for (int c = 0; c < 2; c++)
               pix[y][x][c] = int'($urandom_range(255, 0)) - 128;
   endtask

   // Streams one stored frame into instance s and checks every cycle.
   task automatic run_frame(input int s, input int h, input int w, input int max_gap);
      int ow, oh, nout, last_x, e0, e1, g;
      bit ev, efd;
      ow = w / 2; oh = h / 2; nout = 0; last_x = 0;
      sel = s;
      cap0.delete(); cap1.delete();
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
               @(negedge clk);
               drive(s, 1'b0, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
               @(posedge clk); #1;
               n_chk++;
               if (m_vld !== 1'b0 || (nout > 0 && m_x != last_x)) begin
                  n_fail++;
                  $display("FAIL gap_idle s=%0d (%0d,%0d): out_valid=%b out_x=%0d, required 0 and held %0d",
                           s, x, y, m_vld, m_x, last_x);
               end
            end
            @(negedge clk);
            drive(s, 1'b1, pix[y][x][0], pix[y][x][1]);
            @(posedge clk); #1;
            ev = (y % 2 == 1) && (x % 2 == 1) && (x < 2*ow) && (y < 2*oh);
            n_chk++;
            if (m_vld !== ev) begin
               n_fail++;
               $display("FAIL out_valid s=%0d after pixel (%0d,%0d): got %b, required %b", s, x, y, m_vld, ev);
            end
            if (ev) begin
               e0 = exp_pool(y/2, x/2, 0);
               e1 = exp_pool(y/2, x/2, 1);
               efd = (x/2 == ow-1) && (y/2 == oh-1);
               n_chk++;
               if (m_v0 != e0 || m_v1 != e1 || m_x != x/2 || m_y != y/2 || m_fd !== efd) begin
                  n_fail++;
                  $display("FAIL pooled s=%0d: got v=(%0d,%0d) pos=(%0d,%0d) fd=%b, required v=(%0d,%0d) pos=(%0d,%0d) fd=%b",
                           s, m_v0, m_v1, m_x, m_y, m_fd, e0, e1, x/2, y/2, efd);
               end
               cap0.push_back(m_v0);
               cap1.push_back(m_v1);
               nout++;
               last_x = x / 2;
            end else begin
               n_chk++;
               if (m_fd !== 1'b0) begin
                  n_fail++;
                  $display("FAIL frame_done s=%0d stray pulse at pixel (%0d,%0d): got %b, required 0", s, x, y, m_fd);
               end
            end
         end
      end
      @(negedge clk);
      drive(s, 1'b0, 0, 0);
      n_chk++;
      if (nout != oh * ow) begin
         n_fail++;
         $display("FAIL out_count s=%0d: got %0d, required %0d", s, nout, oh * ow);
      end
   endtask

   task automatic check_ramp4_caps(input string tag);
      int r0 [4];
      int r1 [4];
      r0 = '{5, 7, 13, 15};
      r1 = '{0, -2, -8, -10};
      n_chk++;
      if (cap0.size() != 4) begin
         n_fail++;
         $display("FAIL %s capture count: got %0d, required 4", tag, cap0.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (cap0[i] != r0[i] || cap1[i] != relu_ref(r1[i])) begin
               n_fail++;
               $display("FAIL %s out %0d: got (%0d,%0d), required (%0d,%0d)",
                        tag, i, cap0[i], cap1[i], r0[i], relu_ref(r1[i]));
            end
         end
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_chk++;
         if (m_vld !== 1'b0 || m_fd !== 1'b0 || m_v0 != 0 || m_v1 != 0 || m_x != 0 || m_y != 0) begin
            n_fail++;
            $display("FAIL reset_state s=%0d: got vld=%b fd=%b v=(%0d,%0d) pos=(%0d,%0d), required all 0",
                     s, m_vld, m_fd, m_v0, m_v1, m_x, m_y);
         end
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ramp_4x4();
      fill_ramp(4, 4);
      run_frame(0, 4, 4, 0);
      check_ramp4_caps("ramp4");
   endtask

   task automatic test_odd_5x5();
      int r0 [4];
      r0 = '{6, 8, 16, 18};
      fill_ramp(5, 5);
      for (int f = 0; f < 2; f++) begin
         run_frame(1, 5, 5, 0);
         for (int i = 0; i < 4 && i < cap0.size(); i++) begin
            n_chk++;
            if (cap0[i] != r0[i]) begin
               n_fail++;
               $display("FAIL odd5 frame %0d out %0d: got %0d, required %0d", f, i, cap0[i], r0[i]);
            end
         end
      end
   endtask

   task automatic test_extremes();
      fill_random(4, 4);
      pix[0][0][0] = -128; pix[0][1][0] = 127; pix[1][0][0] = -1; pix[1][1][0] = 0;
      for (int dy = 0; dy < 2; dy++)
         for (int dx = 0; dx < 2; dx++) pix[dy][dx][1] = -128;
      run_frame(0, 4, 4, 0);
      n_chk++;
      if (cap0.size() < 1 || cap0[0] != 127 || cap1[0] != relu_ref(-128)) begin
         n_fail++;
         $display("FAIL extremes: got (%0d,%0d), required (127,%0d)",
                  (cap0.size() > 0) ? cap0[0] : -999, (cap1.size() > 0) ? cap1[0] : -999, relu_ref(-128));
      end
   endtask

   task automatic test_reset_mid_frame();
      fill_ramp(4, 4);
      sel = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(0, 1'b1, pix[i/4][i%4][0], pix[i/4][i%4][1]);
      end
      @(negedge clk);
      drive(0, 1'b0, 0, 0);
      rst = 1'b1;
      #1;
      n_chk++;
      if (m_vld !== 1'b0 || m_fd !== 1'b0 || m_v0 != 0 || m_v1 != 0 || m_x != 0 || m_y != 0) begin
         n_fail++;
         $display("FAIL midframe_reset: got vld=%b v=(%0d,%0d) pos=(%0d,%0d), required all 0",
                  m_vld, m_v0, m_v1, m_x, m_y);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_frame(0, 4, 4, 0);
      check_ramp4_caps("after_reset");
   endtask

   task automatic test_gaps_28();
      fill_random(28, 28);
      run_frame(2, 28, 28, 0);
      run_frame(2, 28, 28, 3);
   endtask

   initial begin
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b0, 0, 0);
      drive(2, 1'b0, 0, 0);
      test_reset();
      test_ramp_4x4();
      test_odd_5x5();
      test_extremes();
      test_reset_mid_frame();
      test_gaps_28();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
